// File: rtl/fact_seq_if.sv
// fact_seq_if: request/response bundle between a controller and the factorial engine.
// The controller drives the operand and start strobe; the engine returns status and result.
interface fact_seq_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8
);
  logic               start;
  logic [N_WIDTH-1:0] number;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   fact;
  logic               overflow;

  modport master (
    output start, number,
    input  busy, done, fact, overflow
  );

  modport slave (
    input  start, number,
    output busy, done, fact, overflow
  );
endinterface

// File: rtl/fact_seq.sv
// fact_seq: sequential factorial engine, one multiply per clock.
// A request is accepted only in IDLE. The result and overflow flag are held until the
// next completion. The overflow flag is sticky across one computation and is cleared
// when the next request is accepted.
module fact_seq #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  fact_seq_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int PW = WIDTH + N_WIDTH;

  localparam logic [WIDTH-1:0]   ACC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [N_WIDTH-1:0] CNT_ONE = {{(N_WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [N_WIDTH-1:0] cnt;
  logic               ovf;
  logic [PW-1:0]      prod;
  logic               prod_hi_nz;

  // Full-width unsigned product of the running value and the current multiplier.
  always_comb begin
    prod       = {{N_WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, cnt};
    prod_hi_nz = (prod[PW-1:WIDTH] != {N_WIDTH{1'b0}});
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= ACC_ONE;
      cnt          <= {N_WIDTH{1'b0}};
      ovf          <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.fact     <= {WIDTH{1'b0}};
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt          <= bus.number;
            acc          <= ACC_ONE;
            ovf          <= 1'b0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          if (cnt > CNT_ONE) begin
            // Count down towards 1 so that cnt never wraps below 1.
            acc <= prod[WIDTH-1:0];
            ovf <= ovf | prod_hi_nz;
            cnt <= cnt - CNT_ONE;
          end else begin
            bus.fact     <= acc;
            bus.overflow <= ovf;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_seq.sv
// tb_fact_seq: directed vectors feeding a scoreboard queue. A monitor pops an expected
// result on every done pulse and checks the value, the overflow flag and the completion cycle.
module tb_fact_seq;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   pushed;
  int   popped;

  typedef struct {
    logic [31:0] fact;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];

  fact_seq_if #(.WIDTH(32), .N_WIDTH(8)) bus ();

  fact_seq #(.WIDTH(32), .N_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp accepted requests and completions.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        popped++;
        check("fact", bus.fact, e.fact);
        check("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
        check("done_cycle", cyc, e.due);
      end
    end
  end

  // Called at posedge+1; drives a one-cycle start and optionally records the expected result.
  task automatic issue(input int n, input bit accepted, input logic [31:0] f, input logic o);
    exp_t e;
    bus.start  = 1'b1;
    bus.number = 8'(n);
    if (accepted) begin
      e.fact = f;
      e.ovf  = o;
      e.due  = cyc + 1 + ((n == 0) ? 1 : n);
      q.push_back(e);
      pushed++;
    end
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask

  // Wait, bounded, until every expected result has been seen and the engine is idle.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
      @(posedge clk) #1;
      n++;
    end
    @(posedge clk) #1;
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, q.size());
    end
  endtask

  initial begin
    int n;
    cyc    = 0;
    total  = 0;
    bad    = 0;
    pushed = 0;
    popped = 0;
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.number = 8'd5;

    // Reset with a simultaneous start request.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_fact", bus.fact, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk) #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_done", {31'd0, bus.done}, 32'd0);

    // Nominal: 5! with busy high for exactly 5 cycles.
    issue(5, 1'b1, 32'd120, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("busy_n5", {31'd0, bus.busy}, 32'd1);
      @(posedge clk) #1;
    end
    check("busy_n5", {31'd0, bus.busy}, 32'd1);
    @(posedge clk) #1;
    check("busy_fall_n5", {31'd0, bus.busy}, 32'd0);
    wait_idle("n5");
    repeat (10) @(posedge clk);
    #1;
    check("fact_hold", bus.fact, 32'd120);

    // Boundary operands.
    issue(0, 1'b1, 32'd1, 1'b0);
    wait_idle("n0");
    issue(1, 1'b1, 32'd1, 1'b0);
    wait_idle("n1");

    // Overflow and clearing of the sticky flag.
    issue(12, 1'b1, 32'd479001600, 1'b0);
    wait_idle("n12");
    issue(13, 1'b1, 32'd1932053504, 1'b1);
    wait_idle("n13");
    issue(3, 1'b1, 32'd6, 1'b0);
    wait_idle("n3");

    // Handshake: a start during CALC is dropped; a start in the done cycle is accepted.
    issue(6, 1'b1, 32'd720, 1'b0);
    @(posedge clk) #1;
    issue(3, 1'b0, 32'd0, 1'b0);
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL done_wait_n6: got no done, expected done within 50 cycles");
    end
    issue(4, 1'b1, 32'd24, 1'b0);
    wait_idle("n4_chain");

    // Abort: reset mid-computation yields no completion.
    issue(10, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk) #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_fact", bus.fact, 32'd0);
    check("abort_overflow", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_restart", {31'd0, bus.busy}, 32'd0);
    issue(4, 1'b1, 32'd24, 1'b0);
    wait_idle("n4_after_abort");

    check("result_count", popped, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
